// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the handshake state encoding and the default bundle widths for each boundary.
// No logic; imported by pipe_slot and pipe_stage_skid.
package pipe_pkg;

    // Handshake state encoding; the encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } pipe_state_e;

    // IF/ID: instruction + PC+4.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    // ID/EX: rs + rt + rd + ReadData1 + ReadData2 + SignExtImm + PC+4.
    localparam int IDEX_CTRL_W  = 10;
    localparam int IDEX_DATA_W  = 143;
    // EX/MEM: write-reg + ALUResult + store data + PC+4.
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 101;
    // MEM/WB: rt + ReadData + ALUResult + PC+4.
    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = 101;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register (control + data bundles), updated on the falling edge.
// Latency: loaded value visible immediately after the loading edge.
// Backpressure: none here; the owner decides when to load or clear.
//
// Ports: clk, reset (async, active-high), load (capture d_*), clr_ctrl (force ctrl
// to RESET_CTRL, data untouched; wins over load), d_ctrl/d_data in, q_ctrl/q_data out.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W     = MEMWB_CTRL_W,
    parameter int                DATA_W     = MEMWB_DATA_W,
    parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_ctrl <= RESET_CTRL;
            q_data <= '0;
        end else if (clr_ctrl) begin
            // Data is left as-is: it is don't-care once the entry is invalid.
            q_ctrl <= RESET_CTRL;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Latency: entry pushed at falling edge N is on out_* right after edge N.
// Backpressure: in_ready depends only on registered state (no out_ready path); full rate while out_ready=1.
//
// Ports: clk (falling-edge), reset (async, active-high), flush (sync discard),
// in_valid/in_ready/in_ctrl/in_data upstream, out_valid/out_ready/out_ctrl/out_data
// downstream, occupancy = number of held entries (0..2).
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                CTRL_W     = MEMWB_CTRL_W,
    parameter int                DATA_W     = MEMWB_DATA_W,
    parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;

    logic              push;
    logic              pop;

    logic              main_load;
    logic              main_from_skid;
    logic              main_clr;
    logic              skid_load;
    logic              skid_clr;

    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = state_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides everything: a coincident push is dropped, and a
    // coincident pop needs no action because the entry is discarded anyway.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = S_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_d   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = S_FULL;
                    end else if (pop) begin
                        main_clr  = 1'b1;
                        state_d   = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = S_ONE;
                    end
                end
                default: begin
                    state_d  = S_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .RESET_CTRL (RESET_CTRL)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .d_ctrl   (main_d_ctrl),
        .d_data   (main_d_data),
        .q_ctrl   (main_ctrl),
        .q_data   (main_data)
    );

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .RESET_CTRL (RESET_CTRL)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clr_ctrl (skid_clr),
        .d_ctrl   (in_ctrl),
        .d_data   (in_data),
        .q_ctrl   (skid_ctrl),
        .q_data   (skid_data)
    );

    // Gate control so an empty or stalled stage never emits live control bits.
    assign out_ctrl = out_valid ? main_ctrl : RESET_CTRL;
    assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (4/101, 1/1, 8/160) share handshake
// stimulus and are compared every cycle against a queue-based FIFO model.
// Directed scenarios first, then a long randomized run.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [7:0]   c;
        logic [159:0] d;
    } ent_t;

    localparam logic [7:0] RC2 = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [7:0]   drv_ctrl;
    logic [159:0] drv_data;

    logic         rdy0, vld0, rdy1, vld1, rdy2, vld2;
    logic [1:0]   occ0, occ1, occ2;
    logic [3:0]   oc0;
    logic [100:0] od0;
    logic [0:0]   oc1;
    logic [0:0]   od1;
    logic [7:0]   oc2;
    logic [159:0] od2;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_skid u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(drv_ctrl[3:0]), .in_data(drv_data[100:0]),
        .out_valid(vld0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
    );

    pipe_stage_skid #(.CTRL_W(1), .DATA_W(1), .RESET_CTRL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(drv_ctrl[0:0]), .in_data(drv_data[0:0]),
        .out_valid(vld1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(160), .RESET_CTRL(RC2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_ctrl(drv_ctrl), .in_data(drv_data),
        .out_valid(vld2), .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2), .occupancy(occ2)
    );

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input logic v, input logic r, input logic [1:0] occ,
                           input logic [7:0] ctrl, input logic [159:0] data,
                           input logic [7:0] cmask, input logic [159:0] dmask, input logic [7:0] rc);
        logic exp_v;
        exp_v = (q.size() != 0);
        chk({tag, "/valid"}, 192'(v), 192'(exp_v));
        chk({tag, "/ready"}, 192'(r), 192'(q.size() < 2));
        chk({tag, "/occ"}, 192'(occ), 192'(q.size()));
        chk({tag, "/occ_max"}, 192'(occ <= 2'd2), 192'(1));
        chk({tag, "/ctrl"}, 192'(ctrl), exp_v ? 192'(q[0].c & cmask) : 192'(rc));
        if (exp_v) chk({tag, "/data"}, 192'(data), 192'(q[0].d & dmask));
    endtask

    task automatic check_all(input string tag);
        chk_dut({tag, "/d0"}, vld0, rdy0, occ0, 8'(oc0), 160'(od0), 8'h0F, {59'd0, {101{1'b1}}}, 8'h00);
        chk_dut({tag, "/d1"}, vld1, rdy1, occ1, 8'(oc1), 160'(od1), 8'h01, 160'd1, 8'h00);
        chk_dut({tag, "/d2"}, vld2, rdy2, occ2, oc2, od2, 8'hFF, {160{1'b1}}, RC2);
    endtask

    // Called just after a rising edge; drives one falling-edge transfer and
    // checks all outputs just after the next rising edge.
    task automatic step(input string tag, input logic iv, input logic [7:0] ic,
                        input logic [159:0] id, input logic ordy, input logic fl);
        bit   push, pop;
        ent_t e;
        in_valid  = iv;
        drv_ctrl  = ic;
        drv_data  = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        push = iv && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        e.c  = ic;
        e.d  = id;
        if (fl) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "/d0_data"}, 192'(od0), 192'(0));
        chk({tag, "/d1_data"}, 192'(od1), 192'(0));
        chk({tag, "/d2_data"}, 192'(od2), 192'(0));
        check_all(tag);
    endtask

    logic [159:0] garbage;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drv_ctrl  = '0;
        drv_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("por");
        reset = 1'b0;
        garbage = {$urandom, $urandom, $urandom, $urandom, $urandom};

        // Fill to FULL, then reset asynchronously before the next falling edge.
        step("rf1", 1'b1, 8'h05, 160'h0A1, 1'b0, 1'b0);
        step("rf2", 1'b1, 8'h05, 160'h0A2, 1'b0, 1'b0);
        chk("rf_occ_full", 192'(occ0), 192'(2));
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        chk_reset_outs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outs("rst_held");
        reset = 1'b0;

        // Streaming at full rate.
        step("st_a", 1'b1, 8'h05, 160'h0A, 1'b1, 1'b0);
        chk("st_a_data", 192'(od0), 192'(8'h0A));
        step("st_b", 1'b1, 8'h05, 160'h0B, 1'b1, 1'b0);
        chk("st_b_data", 192'(od0), 192'(8'h0B));
        chk("st_b_occ", 192'(occ0), 192'(1));
        step("st_c", 1'b1, 8'h05, 160'h0C, 1'b1, 1'b0);
        chk("st_c_data", 192'(od0), 192'(8'h0C));
        chk("st_c_rdy", 192'(rdy0), 192'(1));
        chk("st_c_ctrl", 192'(oc0), 192'(4'b0101));
        step("st_drain", 1'b0, 8'hFF, garbage, 1'b1, 1'b0);

        // Back-pressure: third entry must wait, then all three drain in order.
        step("bp_11", 1'b1, 8'h03, 160'h11, 1'b0, 1'b0);
        step("bp_22", 1'b1, 8'h03, 160'h22, 1'b0, 1'b0);
        chk("bp_occ", 192'(occ0), 192'(2));
        chk("bp_rdy", 192'(rdy0), 192'(0));
        chk("bp_head", 192'(od0), 192'(8'h11));
        step("bp_33_blk", 1'b1, 8'h03, 160'h33, 1'b0, 1'b0);
        chk("bp_33_blk_head", 192'(od0), 192'(8'h11));
        step("bp_rel1", 1'b1, 8'h03, 160'h33, 1'b1, 1'b0);
        chk("bp_rel1_head", 192'(od0), 192'(8'h22));
        step("bp_rel2", 1'b1, 8'h03, 160'h33, 1'b1, 1'b0);
        chk("bp_rel2_head", 192'(od0), 192'(8'h33));
        step("bp_rel3", 1'b0, 8'h00, garbage, 1'b1, 1'b0);
        chk("bp_empty", 192'(vld0), 192'(0));

        // Flush while FULL with a coincident push.
        step("fl_55", 1'b1, 8'h07, 160'h55, 1'b0, 1'b0);
        step("fl_66", 1'b1, 8'h07, 160'h66, 1'b0, 1'b0);
        step("fl_44", 1'b1, 8'h07, 160'h44, 1'b1, 1'b1);
        chk("fl_occ", 192'(occ0), 192'(0));
        chk("fl_ctrl", 192'(oc0), 192'(0));
        step("fl_after", 1'b0, 8'h07, garbage, 1'b1, 1'b0);
        chk("fl_no44", 192'(vld0), 192'(0));

        // Bubble gating after an all-ones control entry leaves.
        step("bb_ff", 1'b1, 8'hFF, 160'h77, 1'b0, 1'b0);
        chk("bb_ff_ctrl", 192'(oc0), 192'(4'b1111));
        step("bb_pop", 1'b0, 8'hFF, garbage, 1'b1, 1'b0);
        chk("bb_gate", 192'(oc0), 192'(0));
        step("bb_push", 1'b1, 8'h02, 160'h88, 1'b0, 1'b0);
        chk("bb_push_ctrl", 192'(oc0), 192'(4'b0010));
        step("bb_drain", 1'b0, 8'h00, garbage, 1'b1, 1'b0);

        // Randomized handshake across all three widths.
        for (int i = 0; i < 10000; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 8'($urandom),
                 {$urandom, $urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-field inter-stage registers (IF/ID … MEM/WB).
- Carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput under back-pressure), synchronous flush, and bubble-safe control gating.
- Instantiated once per pipeline boundary; the stage-specific field packing is done by the instantiating wrapper.

Parameters:
- CTRL_W, 4, width of the control bundle (e.g. MemToReg, Jal, RegWrite, …); all-zero means a no-op bubble.
- DATA_W, 101, width of the packed data bundle (e.g. rt + ReadData + ALUResult + PC+4 = 5+32+32+32).
- RESET_CTRL, 0, CTRL_W-bit value loaded into control registers on reset and flush.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the existing pipeline registers.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry this edge.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  out_ctrl/out_data hold a real entry.
- out_ready  in  1  downstream consumes the entry this edge.
- out_ctrl  out  CTRL_W  control bundle; forced to RESET_CTRL whenever out_valid=0.
- out_data  out  DATA_W  data bundle; value is don't-care when out_valid=0.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main slot (drives the outputs) and skid slot. State is EMPTY(0), ONE(1) or FULL(2); occupancy equals the state encoding.
- in_ready = (state != FULL). This is registered-state-derived, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY:
  - push -> main<=in, go to ONE.
  - otherwise stay.
- ONE:
  - push & pop -> main<=in, stay ONE (full throughput, 1 entry per cycle).
  - push & !pop -> skid<=in, go to FULL.
  - !push & pop -> go to EMPTY, main ctrl<=RESET_CTRL.
  - otherwise hold.
- FULL:
  - pop -> main<=skid, go to ONE.
  - otherwise hold. No push is possible because in_ready=0.
- Ordering: strict FIFO; the skid entry never bypasses main.
- Latency: an entry pushed at falling edge N appears on out_* immediately after edge N (one-edge latency, same as the existing pipeline registers).
- Flush:
  - Highest synchronous priority. At the edge: state<=EMPTY, both ctrl slots<=RESET_CTRL, data slots unchanged.
  - A push coincident with flush is dropped.
  - A pop coincident with flush is counted as consumed (downstream saw it).
- Reset:
  - Asynchronous. Immediately: state=EMPTY, ctrl slots=RESET_CTRL, data slots=0.
  - Outputs during and after reset: out_valid=0, in_ready=1, occupancy=0, out_ctrl=RESET_CTRL, out_data=0.
  - Reset asserted mid-transfer discards all entries without waiting for an edge.
- Bubble safety: out_ctrl = out_valid ? main_ctrl : RESET_CTRL. This is combinational gating, so a stalled or empty stage can never assert RegWrite/MemWrite downstream.
- Inputs are sampled only when in_valid=1; X on in_ctrl/in_data with in_valid=0 must not propagate.
- Assertions for the verification engineer:
  - no push while FULL;
  - occupancy never reaches 3;
  - out_ctrl == RESET_CTRL whenever out_valid=0.

Decomposition:
- Package pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - default CTRL/DATA widths for each stage boundary (IFID_*, IDEX_*, EXMEM_*, MEMWB_*).
- Sub-module pipe_slot: one (CTRL_W+DATA_W) register with load enable, clear-ctrl, and async reset on the falling edge. Instantiated twice (main, skid).
- The handshake FSM stays in the top module.

Test Plan:
- Reset: assert reset mid-cycle with state=FULL -> instantly out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0.
- Streaming: out_ready=1; push ctrl=4'b0101 then data 0x0A, 0x0B, 0x0C on three consecutive edges -> out_data follows one edge later in order; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0, push 0x11 then 0x22 -> occupancy 2, in_ready=0, out_data=0x11. A third in_valid (0x33) is not accepted. Release out_ready -> 0x11, 0x22, then 0x33 in order with no loss or duplication.
- Flush while FULL with in_valid=1 (0x44) -> next edge occupancy=0, out_valid=0, out_ctrl=0; 0x44 never appears.
- Bubble: state EMPTY with main ctrl previously 4'b1111 -> out_ctrl=0 while out_valid=0. Push ctrl=4'b0010 -> out_ctrl=4'b0010 after the edge.
- Parameter sweep: CTRL_W=1/DATA_W=1 and CTRL_W=8/DATA_W=160 under random in_valid/out_ready (10k cycles) -> scoreboard matches exactly; assertions never fire.
